demux8_guarded: RTL

//   Registered 1-to-8 demultiplexer: routes one shared input bit to the selected one of eight outputs.

---
 rtl/demux8_guarded_pkg.sv | 11 +
 rtl/demux8_guarded_guard_timer.sv | 19 +
 rtl/demux8_guarded.sv | 59 +++++
 3 files changed

// File: rtl/demux8_guarded_pkg.sv
// demux8_guarded_pkg: shared state encoding, default guard length and channel decode.
package demux8_guarded_pkg;
  typedef enum logic {ST_ROUTE = 1'b0, ST_BREAK = 1'b1} state_t;
  localparam int GUARD_CYCLES_DEF = 4;
  localparam int CNT_W = 8;
  function automatic logic [7:0] route(input logic [2:0] ch, input logic d, input logic idle);
    logic [7:0] oh;
    oh = 8'b1 << ch;
    return ({8{idle}} & ~oh) | ({8{d}} & oh);
  endfunction
endpackage

// File: rtl/demux8_guarded_guard_timer.sv
// demux8_guarded_guard_timer: loadable down-counter with zero flag for break-before-make guards.
module demux8_guarded_guard_timer #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= RST_VAL;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/demux8_guarded.sv
// demux8_guarded: registered 1-to-8 demux with an all-idle guard interval on every select change.
module demux8_guarded
  import demux8_guarded_pkg::*;
#(
  parameter int   GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  input  logic       x,
  output logic [7:0] y,
  output logic       busy,
  output logic [2:0] active_sel
);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES - 1);
  state_t     r_state;
  logic [2:0] r_target, r_active;
  logic [7:0] r_y;
  logic       r_busy;
  logic       w_hold, w_retarget, w_zero, w_done, w_load, w_dec;
  assign w_hold     = sel == r_active;
  assign w_retarget = sel != r_target;
  assign w_done     = !w_retarget && w_zero;
  assign w_load     = (r_state == ST_ROUTE) ? !w_hold : w_retarget;
  assign w_dec      = (r_state == ST_BREAK) && !w_retarget;
  demux8_guarded_guard_timer #(.W(CNT_W), .RST_VAL(GUARD_LD)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (GUARD_LD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );
  // y stays all-idle throughout BREAK; it is only rewritten in ROUTE or on the reconnect edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= ST_BREAK;
      r_target <= '0;
      r_active <= '0;
      r_y      <= {8{IDLE_LEVEL}};
      r_busy   <= 1'b1;
    end else if (r_state == ST_ROUTE) begin
      r_y    <= w_hold ? route(r_active, x, IDLE_LEVEL) : {8{IDLE_LEVEL}};
      r_busy <= !w_hold;
      if (!w_hold) begin
        r_target <= sel;
        r_state  <= ST_BREAK;
      end
    end else if (w_done) begin
      r_active <= r_target;
      r_y      <= route(r_target, x, IDLE_LEVEL);
      r_busy   <= 1'b0;
      r_state  <= ST_ROUTE;
    end else if (w_retarget) r_target <= sel;
  assign y          = r_y;
  assign busy       = r_busy;
  assign active_sel = r_active;
endmodule
